nios2_fp_sysid_uptime: RTL and testbench

//  Parametrised system-ID slave on the Nios II Avalon-MM bus. Returns build ID and build

---
 rtl/nios2_fp_sysid_uptime.sv | 144 ++++++++++++++
 tb/tb_nios2_fp_sysid_uptime.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_fp_sysid_uptime.sv
// System-ID slave for the Nios II Avalon-MM bus: build ID/timestamp, a 64-bit uptime
// counter with coherent lo/hi reads, freeze/clear control, scratch registers and a tick.
module nios2_fp_sysid_uptime #(
  parameter logic [31:0] SYSID_ID     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'd1457881118,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned NUM_SCRATCH  = 2,
  parameter int unsigned ADDR_W       = 3,
  parameter logic [63:0] UPTIME_RESET = 64'd0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              tick
);

  localparam int unsigned PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCR_N      = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
  localparam int unsigned SCR_BASE   = 5;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  localparam logic [ADDR_W-1:0] A_ID     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TSTAMP = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_UP_LO  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_UP_HI  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(4);

  // Parameter sanity: the map must fit the address space and the divider must be non-zero.
  if (SCR_BASE + NUM_SCRATCH > (2 ** ADDR_W)) begin : g_bad_map
    $error("nios2_fp_sysid_uptime: 5+NUM_SCRATCH exceeds 2**ADDR_W");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("nios2_fp_sysid_uptime: TICK_DIV must be >= 1");
  end

  logic [PRE_W-1:0] prescaler;
  logic [63:0]      uptime;
  logic [31:0]      shadow_hi;
  logic             freeze;
  logic [31:0]      scratch [SCR_N];

  logic             wrap_c;
  logic             wr_ctrl_c;
  logic             clear_c;
  logic             rd_up_lo_c;
  logic [SCR_N-1:0] scr_hit_c;
  logic [31:0]      ctrl_rd_c;
  logic [31:0]      rd_data_c;

  assign wrap_c     = (prescaler == PRE_MAX);
  assign wr_ctrl_c  = write && (address == A_CTRL) && byteenable[0];
  assign clear_c    = wr_ctrl_c && writedata[1];
  assign rd_up_lo_c = read && (address == A_UP_LO);
  assign ctrl_rd_c  = {16'h0000, 8'(NUM_SCRATCH), 7'h00, freeze};

  // Scratch word select; entries past NUM_SCRATCH never match.
  always_comb begin
    scr_hit_c = '0;
    for (int i = 0; i < SCR_N; i++) begin
      scr_hit_c[i] = (unsigned'(i) < NUM_SCRATCH) && (address == ADDR_W'(SCR_BASE + unsigned'(i)));
    end
  end

  // Read mux on pre-edge state; unmapped words return zero.
  always_comb begin
    rd_data_c = '0;
    case (address)
      A_ID:     rd_data_c = SYSID_ID;
      A_TSTAMP: rd_data_c = TIMESTAMP;
      A_UP_LO:  rd_data_c = uptime[31:0];
      A_UP_HI:  rd_data_c = shadow_hi;
      A_CTRL:   rd_data_c = ctrl_rd_c;
      default: begin
        for (int i = 0; i < SCR_N; i++) begin
          if (scr_hit_c[i]) rd_data_c = scratch[i];
        end
      end
    endcase
  end

  // Read response: data and a one-cycle valid, data held until the next read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_data_c;
    end
  end

  // Prescaler and tick keep running while frozen; clear restarts the prescaler.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      tick      <= 1'b0;
    end else begin
      tick <= wrap_c;
      if (clear_c || wrap_c) prescaler <= '0;
      else                   prescaler <= prescaler + PRE_W'(1);
    end
  end

  // Uptime and its hi shadow; clear wins over a coincident increment or LO read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime    <= UPTIME_RESET;
      shadow_hi <= '0;
    end else if (clear_c) begin
      uptime    <= UPTIME_RESET;
      shadow_hi <= '0;
    end else begin
      if (wrap_c && !freeze) uptime <= uptime + 64'd1;
      if (rd_up_lo_c)        shadow_hi <= uptime[63:32];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) freeze <= 1'b0;
    else if (wr_ctrl_c) freeze <= writedata[0];
  end

  // Scratch registers with per-lane byte enables.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SCR_N; i++) scratch[i] <= '0;
    end else if (write) begin
      for (int i = 0; i < SCR_N; i++) begin
        if (scr_hit_c[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) scratch[i][8*b +: 8] <= writedata[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nios2_fp_sysid_uptime.sv
// Directed bench for nios2_fp_sysid_uptime: three instances share one bus (TICK_DIV=4 from
// zero, TICK_DIV=4 from 0xFFFF_FFFE, TICK_DIV=1) and each scenario checks hand-computed values.
module tb_nios2_fp_sysid_uptime;

  logic        clock;
  logic        reset_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] rd_a, rd_b, rd_c;
  logic        rdv_a, rdv_b, rdv_c;
  logic        tick_a, tick_b, tick_c;

  int checks = 0;
  int errors = 0;

  nios2_fp_sysid_uptime #(.TICK_DIV(4), .UPTIME_RESET(64'd0)) dut_a (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rd_a),
    .readdatavalid(rdv_a), .tick(tick_a));

  nios2_fp_sysid_uptime #(.TICK_DIV(4), .UPTIME_RESET(64'h0000_0000_FFFF_FFFE)) dut_b (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rd_b),
    .readdatavalid(rdv_b), .tick(tick_b));

  nios2_fp_sysid_uptime #(.TICK_DIV(1)) dut_c (
    .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rd_c),
    .readdatavalid(rdv_c), .tick(tick_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every bus task ends 1 ns after the posedge it was sampled on.
  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic do_read(input logic [2:0] a);
    @(negedge clock);
    read    = 1'b1;
    write   = 1'b0;
    address = a;
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clock);
    read       = 1'b0;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    byteenable = be;
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    @(negedge clock);
    read  = 1'b0;
    write = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rd_a, rdv_a, tick_a, tick_c, rdv_c} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%h rdv=%b tick_a=%b tick_c=%b, expected all 0",
               rd_a, rdv_a, tick_a, tick_c);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_edges(1);
    checks++;
    if (rdv_a !== 1'b0 || tick_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdv=%b tick=%b, expected 0 0", rdv_a, tick_a);
    end
    checks++;
    if (tick_c !== 1'b1) begin
      errors++;
      $display("FAIL tickdiv1_first: got %b expected 1", tick_c);
    end
  endtask

  task automatic test_id_reads();
    int pulses;
    pulses = 0;
    apply_reset();
    do_read(3'd0);
    pulses += int'(rdv_a);
    checks++;
    if (rd_a !== 32'h0 || rdv_a !== 1'b1) begin
      errors++;
      $display("FAIL read_id: got %h/%b expected 00000000/1", rd_a, rdv_a);
    end
    do_read(3'd1);
    pulses += int'(rdv_a);
    checks++;
    if (rd_a !== 32'd1457881118 || rdv_a !== 1'b1) begin
      errors++;
      $display("FAIL read_timestamp: got %h/%b expected %h/1", rd_a, rdv_a, 32'd1457881118);
    end
    do_read(3'd4);
    pulses += int'(rdv_a);
    checks++;
    if (rd_a !== 32'h0000_0200 || rdv_a !== 1'b1) begin
      errors++;
      $display("FAIL read_ctrl: got %h/%b expected 00000200/1", rd_a, rdv_a);
    end
    bus_idle();
    pulses += int'(rdv_a);
    bus_idle();
    pulses += int'(rdv_a);
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL rdv_pulses: got %0d expected 3", pulses);
    end
    checks++;
    if (rd_a !== 32'h0000_0200) begin
      errors++;
      $display("FAIL readdata_hold: got %h expected 00000200", rd_a);
    end
  endtask

  task automatic test_count();
    int ticks, last, bad_period, c_low;
    ticks = 0; last = -1; bad_period = 0; c_low = 0;
    apply_reset();
    for (int e = 2; e <= 40; e++) begin
      wait_edges(1);
      if (tick_a) begin
        ticks++;
        if (last >= 0 && e - last != 4) bad_period++;
        last = e;
      end
      if (tick_c !== 1'b1) c_low++;
    end
    checks++;
    if (ticks != 10) begin
      errors++;
      $display("FAIL tick_count: got %0d expected 10", ticks);
    end
    checks++;
    if (bad_period != 0 || last != 40) begin
      errors++;
      $display("FAIL tick_period: got %0d bad intervals, last at %0d, expected 0 and 40",
               bad_period, last);
    end
    checks++;
    if (c_low != 0) begin
      errors++;
      $display("FAIL tickdiv1_const: got %0d low cycles expected 0", c_low);
    end
    do_read(3'd2);
    checks++;
    if (rd_a !== 32'd10) begin
      errors++;
      $display("FAIL uptime_40clk: got %0d expected 10", rd_a);
    end
    bus_idle();
  endtask

  task automatic test_coherence();
    apply_reset();
    wait_edges(7);
    do_read(3'd2);
    checks++;
    if (rd_b !== 32'h0 || rdv_b !== 1'b1) begin
      errors++;
      $display("FAIL carry_lo: got %h/%b expected 00000000/1", rd_b, rdv_b);
    end
    do_read(3'd3);
    checks++;
    if (rd_b !== 32'h1) begin
      errors++;
      $display("FAIL carry_hi: got %h expected 00000001", rd_b);
    end
    bus_idle();
    apply_reset();
    wait_edges(6);
    do_read(3'd2);
    checks++;
    if (rd_b !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL lo_at_wrap: got %h expected ffffffff", rd_b);
    end
    do_read(3'd3);
    checks++;
    if (rd_b !== 32'h0) begin
      errors++;
      $display("FAIL hi_coherent: got %h expected 00000000", rd_b);
    end
    bus_idle();
  endtask

  task automatic test_freeze_clear();
    int ticks;
    bit found;
    ticks = 0;
    found = 1'b0;
    apply_reset();
    wait_edges(5);
    do_write(3'd4, 32'h1, 4'b0001);
    bus_idle();
    do_read(3'd2);
    checks++;
    if (rd_a !== 32'd1) begin
      errors++;
      $display("FAIL freeze_start: got %0d expected 1", rd_a);
    end
    read = 1'b0;
    repeat (80) begin
      wait_edges(1);
      ticks += int'(tick_a);
    end
    checks++;
    if (ticks != 20) begin
      errors++;
      $display("FAIL frozen_ticks: got %0d expected 20", ticks);
    end
    do_read(3'd2);
    checks++;
    if (rd_a !== 32'd1) begin
      errors++;
      $display("FAIL frozen_value: got %0d expected 1", rd_a);
    end
    do_read(3'd4);
    checks++;
    if (rd_a !== 32'h0000_0201) begin
      errors++;
      $display("FAIL ctrl_freeze_rd: got %h expected 00000201", rd_a);
    end
    do_write(3'd4, 32'h0, 4'b1111);
    bus_idle();
    for (int k = 0; k < 8 && !found; k++) begin
      wait_edges(1);
      if (tick_a) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL tick_sync: got no tick in 8 cycles, expected one");
    end
    // Next wrap is 4 edges after the observed tick; clear lands on it.
    wait_edges(3);
    do_write(3'd4, 32'h2, 4'b0001);
    do_read(3'd2);
    checks++;
    if (rd_a !== 32'd0) begin
      errors++;
      $display("FAIL clear_at_wrap: got %0d expected 0", rd_a);
    end
    do_read(3'd4);
    checks++;
    if (rd_a !== 32'h0000_0200) begin
      errors++;
      $display("FAIL clear_unfreeze: got %h expected 00000200", rd_a);
    end
    bus_idle();
    wait_edges(2);
    do_write(3'd4, 32'h2, 4'b0001);
    bus_idle();
    wait_edges(2);
    checks++;
    if (tick_a !== 1'b0) begin
      errors++;
      $display("FAIL clear_prescaler_early: got tick %b expected 0", tick_a);
    end
    wait_edges(1);
    checks++;
    if (tick_a !== 1'b1) begin
      errors++;
      $display("FAIL clear_prescaler_wrap: got tick %b expected 1", tick_a);
    end
  endtask

  task automatic test_scratch();
    apply_reset();
    do_write(3'd5, 32'hAABB_CCDD, 4'b0101);
    do_read(3'd5);
    checks++;
    if (rd_a !== 32'h00BB_00DD) begin
      errors++;
      $display("FAIL scratch_be: got %h expected 00bb00dd", rd_a);
    end
    do_write(3'd7, 32'h1234_5678, 4'b1111);
    do_read(3'd7);
    checks++;
    if (rd_a !== 32'h0 || rdv_a !== 1'b1) begin
      errors++;
      $display("FAIL unmapped: got %h/%b expected 00000000/1", rd_a, rdv_a);
    end
    do_write(3'd6, 32'hCAFE_F00D, 4'b1111);
    do_read(3'd6);
    checks++;
    if (rd_a !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL scratch6: got %h expected cafef00d", rd_a);
    end
    do_write(3'd4, 32'h1, 4'b1110);
    do_read(3'd4);
    checks++;
    if (rd_a !== 32'h0000_0200) begin
      errors++;
      $display("FAIL ctrl_be0_off: got %h expected 00000200", rd_a);
    end
    @(negedge clock);
    read = 1'b1; write = 1'b1; address = 3'd5;
    writedata = 32'h1122_3344; byteenable = 4'b1111;
    @(posedge clock);
    #1;
    checks++;
    if (rd_a !== 32'h00BB_00DD) begin
      errors++;
      $display("FAIL rw_same_cycle: got %h expected 00bb00dd", rd_a);
    end
    do_read(3'd5);
    checks++;
    if (rd_a !== 32'h1122_3344) begin
      errors++;
      $display("FAIL rw_write_applied: got %h expected 11223344", rd_a);
    end
    bus_idle();
  endtask

  task automatic test_async_reset();
    int stray;
    stray = 0;
    apply_reset();
    wait_edges(9);
    do_read(3'd2);
    checks++;
    if (rd_a !== 32'd2 || rdv_a !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_read: got %0d/%b expected 2/1", rd_a, rdv_a);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rd_a !== 32'h0 || rdv_a !== 1'b0 || tick_c !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rd=%h rdv=%b tick_c=%b expected 0 0 0", rd_a, rdv_a, tick_c);
    end
    @(negedge clock);
    read    = 1'b0;
    reset_n = 1'b1;
    repeat (3) begin
      wait_edges(1);
      stray += int'(rdv_a);
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL stray_rdv: got %0d pulses expected 0", stray);
    end
    wait_edges(2);
    do_read(3'd2);
    checks++;
    if (rd_a !== 32'd1) begin
      errors++;
      $display("FAIL uptime_restart: got %0d expected 1", rd_a);
    end
    bus_idle();
  endtask

  initial begin
    reset_n    = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    byteenable = '0;
    test_reset();
    test_id_reads();
    test_count();
    test_coherence();
    test_freeze_clear();
    test_scratch();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
